mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter sharing one unified instruction/data memory between the fetch stage (PC_F/instr_F) and the memory stage (ALUResult_M, WriteData_M, MemRead_M, MemWrite_M) of the 5-stage MIPS pipeline. It serialises the two requesters onto one request/acknowledge memory port and raises a stall request that the hazard unit ORs into its pipeline stall and flush logic. Data accesses win over fetches, because the M-stage instruction is older. A watchdog bounds every access.

## Interface
Parameters:
- TIMEOUT, 16: max cycles in ISSUE waiting for mem_ack; 0 disables the watchdog.
- BAD_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  32  fetch address (PC_F).
- if_rdata  out  32  fetched instruction; valid when if_ack=1.
- if_ack  out  1  one-cycle completion pulse for the fetch.
- dm_rd / dm_wr  in  1  data read / write request (MemRead_M / MemWrite_M); mutually exclusive; held until dm_ack.
- dm_addr  in  32  data address (ALUResult_M).
- dm_wdata  in  32  store data (WriteData_M).
- dm_rdata  out  32  load data (ReadData_M); valid when dm_ack=1.
- dm_ack  out  1  one-cycle completion pulse for the data access.
- stall  out  1  (if_req & ~if_ack) | ((dm_rd|dm_wr) & ~dm_ack); combinational.
- mem_req, mem_we  out  1  memory request and write enable; registered.
- mem_addr, mem_wdata  out  32  memory address and write data; registered.
- mem_rdata  in  32  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- err  out  1  sticky timeout flag.

## Operation
States: IDLE, ISSUE, RESP.
- IDLE: if a data request is pending, latch the data address/wdata/we into the mem_* registers, set owner=DM and go to ISSUE. Otherwise, if if_req is pending, latch the fetch with mem_we=0, set owner=IF and go to ISSUE. Otherwise stay in IDLE.
- ISSUE: mem_req=1 and all mem_* outputs are held stable.
  - On mem_ack: capture mem_rdata into the owner's rdata register, drop mem_req and go to RESP.
  - If the watchdog counter reaches TIMEOUT first: drop mem_req, load BAD_DATA into the owner's rdata register, set err and go to RESP.
- RESP: pulse the owner's ack for one cycle, then go to IDLE.
  - The requester is still presenting the completed request in this cycle, so no arbitration is done in RESP.
- On a write, dm_rdata keeps its previous value.
- Rdata registers hold their value until the next completion for the same requester.
- Watchdog counter: 0 on entry to ISSUE, incremented each ISSUE cycle without mem_ack, saturating. mem_ack in the same cycle the count reaches TIMEOUT counts as a success.
- err clears only on reset.

## Timing
- Reset (RST=0 at an edge): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_ack=0, dm_ack=0, err=0, counters=0.
- Reset mid-ISSUE abandons the memory transaction; mem_req is low from the next cycle.
- Minimum latency: request seen in IDLE at cycle n, mem_req at n+1, zero-wait mem_ack at n+1, ack pulse at n+2. Three cycles per access; each added memory wait state adds one cycle.
- Both requests pending in IDLE: the data access completes first. The fetch issues in the IDLE cycle after the data RESP. Worst case the fetch waits one full data access plus one cycle.
- stall is low in the ack cycle, so the pipeline advances at that cycle's edge.

## Configuration
- MEM_ARBITER_PERF_EN defined: adds three 32-bit outputs. Each wraps at 2^32 and resets to 0.
  - perf_if: completed fetches.
  - perf_dm: completed data accesses.
  - perf_conflict: cycles in which if_req is pending while owner=DM or a data request is pending in IDLE.
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

## Structure
- Package mem_arbiter_pkg: state enum (IDLE/ISSUE/RESP), owner enum (IF/DM), default BAD_DATA constant.
- Sub-module mem_arbiter_perf holds the counters; instantiated only under MEM_ARBITER_PERF_EN.

## Test plan
- Fetch only, zero-wait: if_req at cycle 0, if_addr=0x0000_0040, memory returns 0x2408_0005 -> mem_req=1 with mem_addr=0x40 at cycle 1; if_ack=1 with if_rdata=0x2408_0005 at cycle 2; stall=0 at cycle 2.
- Simultaneous requests: dm_rd with addr 0x100 (mem returns 0x0000_00AA) and if_req with addr 0x44 at cycle 0 -> dm_ack at cycle 2 with dm_rdata=0xAA; mem_addr=0x44 at cycle 4; if_ack at cycle 5; stall high for cycles 0-4 except the dm_ack cycle, where it reflects only if_req.
- Store with 2 wait states: dm_wr, addr 0x200, wdata 0x1234_5678 -> mem_we=1 and mem_wdata=0x1234_5678 held for 3 ISSUE cycles; dm_ack one cycle after mem_ack; dm_rdata unchanged.
- Timeout with TIMEOUT=4 and mem_ack never asserted -> after 4 ISSUE cycles mem_req drops; if_ack with if_rdata=0xDEAD_BEEF; err=1 and stays 1 until reset.
- Reset during ISSUE: RST=0 at cycle 2 -> mem_req=0, err=0 and both acks 0 from cycle 3; the next request after release completes normally.
- With MEM_ARBITER_PERF_EN: run the simultaneous scenario -> perf_dm=1, perf_if=1, perf_conflict=4.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the unified-memory arbiter.
// FSM states, access owner and the default timeout read data.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam logic [31:0] BAD_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arbiter_perf.sv
// mem_arbiter_perf: wrapping event counters for the memory arbiter.
// Compiled only when MEM_ARBITER_PERF_EN is defined.
`ifdef MEM_ARBITER_PERF_EN
module mem_arbiter_perf (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_done,
  input  logic        dm_done,
  input  logic        conflict,
  output logic [31:0] perf_if,
  output logic [31:0] perf_dm,
  output logic [31:0] perf_conflict
);

  always_ff @(posedge CLK) begin
    if (!RST) begin
      perf_if       <= '0;
      perf_dm       <= '0;
      perf_conflict <= '0;
    end else begin
      if (if_done)
        perf_if <= perf_if + 32'd1;
      if (dm_done)
        perf_dm <= perf_dm + 32'd1;
      if (conflict)
        perf_conflict <= perf_conflict + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto one memory port.
// Define MEM_ARBITER_PERF_EN to add perf_if/perf_dm/perf_conflict.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] BAD_DATA = BAD_DATA_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0] perf_if,
  output logic [31:0] perf_dm,
  output logic [31:0] perf_conflict
`endif
);

  state_t      state;
  owner_t      owner;
  logic [31:0] wd_cnt;
  logic        dm_pend;
  logic        wd_fire;
  logic        done;

  assign dm_pend = dm_rd | dm_wr;
  assign stall   = (if_req & ~if_ack) | (dm_pend & ~dm_ack);
  assign wd_fire = (TIMEOUT != 0) && (wd_cnt == TIMEOUT - 1);
  assign done    = mem_ack | wd_fire;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      owner     <= OWN_IF;
      wd_cnt    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          wd_cnt <= '0;
          // The M-stage access is older, so it wins
          if (dm_pend) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_wr;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            owner     <= OWN_DM;
            state     <= ISSUE;
          end else if (if_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            owner    <= OWN_IF;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (done) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (!mem_ack)
              err <= 1'b1;
            if (owner == OWN_IF) begin
              if_ack   <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : BAD_DATA;
            end else begin
              dm_ack <= 1'b1;
              if (!mem_we)
                dm_rdata <= mem_ack ? mem_rdata : BAD_DATA;
            end
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  logic conflict;

  assign conflict = if_req &
    ((owner == OWN_DM) | ((state == IDLE) & dm_pend));

  mem_arbiter_perf u_perf (
    .CLK           (CLK),
    .RST           (RST),
    .if_done       (if_ack),
    .dm_done       (dm_ack),
    .conflict      (conflict),
    .perf_if       (perf_if),
    .perf_dm       (perf_dm),
    .perf_conflict (perf_conflict)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter
// against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        dm_rd = 1'b0;
  logic        dm_wr = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] perf_if;
  logic [31:0] perf_dm;
  logic [31:0] perf_conflict;
`endif

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ack    (dm_ack),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
`ifdef MEM_ARBITER_PERF_EN
    ,
    .perf_if       (perf_if),
    .perf_dm       (perf_dm),
    .perf_conflict (perf_conflict)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory contents as a pure function of address
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h40)
      return 32'h2408_0005;
    if (a == 32'h100)
      return 32'h0000_00AA;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Responder: acks after a chosen number of wait states
  bit rand_mode = 1'b0;
  int dir_wait = 0;
  int rnd_wait = 0;
  int wait_cnt = 0;

  assign mem_rdata = mem_fn(mem_addr);
  assign mem_ack = mem_req &&
    (wait_cnt == (rand_mode ? rnd_wait : dir_wait));

  always @(posedge CLK) begin
    if (mem_req && !mem_ack)
      wait_cnt <= wait_cnt + 1;
    else
      wait_cnt <= 0;
    if (!mem_req)
      rnd_wait <= int'($urandom_range(0, 5));
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level model
  int          cyc = 0;
  bit          m_busy = 0;
  bit          m_dm = 0;
  bit          m_own_dm = 0;
  bit          m_we = 0;
  bit          m_to = 0;
  int          m_start = 0;
  int          m_ack = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] e_if_rd = '0;
  logic [31:0] e_dm_rd = '0;
  bit          e_err = 0;
  logic [31:0] e_pif = '0;
  logic [31:0] e_pdm = '0;
  logic [31:0] e_pcf = '0;

  task automatic step();
    bit e_req, e_ia, e_da, e_st, dmp;
    int w;
    #1;
    if (m_busy && cyc == m_start) begin
      w = rand_mode ? rnd_wait : dir_wait;
      m_to = (w >= TO);
      m_ack = m_start + (m_to ? TO : w + 1);
    end
    e_req = m_busy && cyc >= m_start && cyc < m_ack;
    e_ia = m_busy && cyc == m_ack && !m_dm;
    e_da = m_busy && cyc == m_ack && m_dm;
    if (e_ia)
      e_if_rd = m_to ? BAD : mem_fn(m_addr);
    if (e_da && !m_we)
      e_dm_rd = m_to ? BAD : mem_fn(m_addr);
    if ((e_ia || e_da) && m_to)
      e_err = 1;
    dmp = dm_rd | dm_wr;
    e_st = (if_req & ~e_ia) | (dmp & ~e_da);
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("if_ack", 32'(if_ack), 32'(e_ia));
    chk("dm_ack", 32'(dm_ack), 32'(e_da));
    chk("if_rdata", if_rdata, e_if_rd);
    chk("dm_rdata", dm_rdata, e_dm_rd);
    chk("err", 32'(err), 32'(e_err));
    chk("stall", 32'(stall), 32'(e_st));
    if (e_req) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_we", 32'(mem_we), 32'(m_we));
      if (m_we)
        chk("mem_wdata", mem_wdata, m_wdata);
    end
`ifdef MEM_ARBITER_PERF_EN
    chk("perf_if", perf_if, e_pif);
    chk("perf_dm", perf_dm, e_pdm);
    chk("perf_conflict", perf_conflict, e_pcf);
`endif
    if (!RST) begin
      m_busy = 0;
      m_own_dm = 0;
      e_if_rd = '0;
      e_dm_rd = '0;
      e_err = 0;
      e_pif = '0;
      e_pdm = '0;
      e_pcf = '0;
    end else begin
      if (e_ia)
        e_pif++;
      if (e_da)
        e_pdm++;
      if (if_req && (m_own_dm || (!m_busy && dmp)))
        e_pcf++;
      if (e_ia || e_da) begin
        m_busy = 0;
      end else if (!m_busy && (dmp || if_req)) begin
        m_busy = 1;
        m_start = cyc + 1;
        m_ack = cyc + 1000000;
        m_dm = dmp;
        m_own_dm = dmp;
        m_addr = dmp ? dm_addr : if_addr;
        m_we = dmp && dm_wr;
        m_wdata = dm_wdata;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (e_ia)
      if_req = 0;
    if (e_da) begin
      dm_rd = 0;
      dm_wr = 0;
    end
    #1;
  endtask

`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] b_if, b_dm, b_cf;
`endif

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    // Reset state
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst dm_rdata", dm_rdata, 32'd0);
    chk("rst acks", 32'({if_ack, dm_ack}), 32'd0);
    chk("rst err", 32'(err), 32'd0);

    // Fetch only, zero wait
    dir_wait = 0;
    if_req = 1;
    if_addr = 32'h40;
    step();
    chk("f0 mem_req", 32'(mem_req), 32'd1);
    chk("f0 mem_addr", mem_addr, 32'h40);
    step();
    chk("f0 if_ack", 32'(if_ack), 32'd1);
    chk("f0 if_rdata", if_rdata, 32'h2408_0005);
    chk("f0 stall", 32'(stall), 32'd0);
    step();

    // Simultaneous fetch and load
`ifdef MEM_ARBITER_PERF_EN
    b_if = perf_if;
    b_dm = perf_dm;
    b_cf = perf_conflict;
`endif
    dm_rd = 1;
    dm_addr = 32'h100;
    if_req = 1;
    if_addr = 32'h44;
    step();
    step();
    chk("sim dm_ack", 32'(dm_ack), 32'd1);
    chk("sim dm_rdata", dm_rdata, 32'hAA);
    chk("sim stall", 32'(stall), 32'd1);
    step();
    step();
    chk("sim mem_addr", mem_addr, 32'h44);
    step();
    chk("sim if_ack", 32'(if_ack), 32'd1);
    chk("sim if_rdata", if_rdata, mem_fn(32'h44));
    step();
`ifdef MEM_ARBITER_PERF_EN
    chk("sim perf_if", perf_if - b_if, 32'd1);
    chk("sim perf_dm", perf_dm - b_dm, 32'd1);
    chk("sim perf_cf", perf_conflict - b_cf, 32'd4);
`endif

    // Store with two wait states
    dir_wait = 2;
    dm_wr = 1;
    dm_addr = 32'h200;
    dm_wdata = 32'h1234_5678;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("st mem_req", 32'(mem_req), 32'd1);
      chk("st mem_we", 32'(mem_we), 32'd1);
      chk("st mem_wdata", mem_wdata, 32'h1234_5678);
      step();
    end
    chk("st dm_ack", 32'(dm_ack), 32'd1);
    chk("st dm_rdata", dm_rdata, 32'hAA);
    step();

    // Fetch timeout
    dir_wait = 100;
    if_req = 1;
    if_addr = 32'h80;
    step();
    for (int i = 0; i < TO; i++) begin
      chk("to mem_req", 32'(mem_req), 32'd1);
      step();
    end
    chk("to mem_req drop", 32'(mem_req), 32'd0);
    chk("to if_ack", 32'(if_ack), 32'd1);
    chk("to if_rdata", if_rdata, BAD);
    chk("to err", 32'(err), 32'd1);
    repeat (4) step();
    chk("to err sticky", 32'(err), 32'd1);

    // Reset during ISSUE
    dm_rd = 1;
    dm_addr = 32'h300;
    step();
    step();
    RST = 0;
    step();
    chk("rr mem_req", 32'(mem_req), 32'd0);
    chk("rr err", 32'(err), 32'd0);
    chk("rr acks", 32'({if_ack, dm_ack}), 32'd0);
    RST = 1;
    dm_rd = 0;
    dir_wait = 1;
    step();
    if_req = 1;
    if_addr = 32'h40;
    repeat (3) step();
    chk("rr if_ack", 32'(if_ack), 32'd1);
    chk("rr if_rdata", if_rdata, 32'h2408_0005);
    step();

    // Random traffic and wait states
    rand_mode = 1;
    step();
    repeat (800) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1;
        if_addr = $urandom & 32'h0000_0FFC;
      end
      if (!dm_rd && !dm_wr && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1)
          dm_wr = 1;
        else
          dm_rd = 1;
        dm_addr = $urandom & 32'h0000_0FFC;
        dm_wdata = $urandom;
      end
      step();
    end
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
